// File: rtl/sigmoid_pkg.sv
// Shared widths and constants for the Q4.4 -> Q0.8 sigmoid lookup.
package sigmoid_pkg;

  localparam int unsigned IN_W      = 8;
  localparam int unsigned IN_FRAC   = 4;
  localparam int unsigned OUT_W     = 8;
  localparam int unsigned TBL_W     = 9;
  localparam int unsigned TBL_DEPTH = 128;
  localparam int unsigned ADDR_W    = $clog2(TBL_DEPTH);

  // T = 256 represents exactly 1.0, which the 8-bit output cannot hold
  localparam logic [TBL_W-1:0] TBL_ONE = TBL_W'(256);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(255);

endpackage

// File: rtl/sigmoid_rom.sv
// Combinational table T[k] = round(256 * sigmoid(k/16)) for k = 0..127.
module sigmoid_rom
  import sigmoid_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output logic [TBL_W-1:0]  t_o
);

  // Entries 100..127 are all 256 and are covered by the default arm
  always_comb begin
    t_o = TBL_ONE;
    case (addr_i)
      7'd0:  t_o = 9'd128;  7'd1:  t_o = 9'd132;  7'd2:  t_o = 9'd136;  7'd3:  t_o = 9'd140;
      7'd4:  t_o = 9'd144;  7'd5:  t_o = 9'd148;  7'd6:  t_o = 9'd152;  7'd7:  t_o = 9'd156;
      7'd8:  t_o = 9'd159;  7'd9:  t_o = 9'd163;  7'd10: t_o = 9'd167;  7'd11: t_o = 9'd170;
      7'd12: t_o = 9'd174;  7'd13: t_o = 9'd177;  7'd14: t_o = 9'd181;  7'd15: t_o = 9'd184;
      7'd16: t_o = 9'd187;  7'd17: t_o = 9'd190;  7'd18: t_o = 9'd193;  7'd19: t_o = 9'd196;
      7'd20: t_o = 9'd199;  7'd21: t_o = 9'd202;  7'd22: t_o = 9'd204;  7'd23: t_o = 9'd207;
      7'd24: t_o = 9'd209;  7'd25: t_o = 9'd212;  7'd26: t_o = 9'd214;  7'd27: t_o = 9'd216;
      7'd28: t_o = 9'd218;  7'd29: t_o = 9'd220;  7'd30: t_o = 9'd222;  7'd31: t_o = 9'd224;
      7'd32: t_o = 9'd225;  7'd33: t_o = 9'd227;  7'd34: t_o = 9'd229;  7'd35: t_o = 9'd230;
      7'd36: t_o = 9'd232;  7'd37: t_o = 9'd233;  7'd38: t_o = 9'd234;  7'd39: t_o = 9'd235;
      7'd40: t_o = 9'd237;  7'd41: t_o = 9'd238;  7'd42: t_o = 9'd239;  7'd43: t_o = 9'd240;
      7'd44: t_o = 9'd241;  7'd45: t_o = 9'd241;  7'd46: t_o = 9'd242;  7'd47: t_o = 9'd243;
      7'd48: t_o = 9'd244;  7'd49: t_o = 9'd245;  7'd50: t_o = 9'd245;  7'd51: t_o = 9'd246;
      7'd52: t_o = 9'd246;  7'd53: t_o = 9'd247;  7'd54: t_o = 9'd248;  7'd55: t_o = 9'd248;
      7'd56: t_o = 9'd248;  7'd57: t_o = 9'd249;  7'd58: t_o = 9'd249;  7'd59: t_o = 9'd250;
      7'd60: t_o = 9'd250;  7'd61: t_o = 9'd250;  7'd62: t_o = 9'd251;  7'd63: t_o = 9'd251;
      7'd64: t_o = 9'd251;  7'd65: t_o = 9'd252;  7'd66: t_o = 9'd252;  7'd67: t_o = 9'd252;
      7'd68: t_o = 9'd252;  7'd69: t_o = 9'd253;  7'd70: t_o = 9'd253;  7'd71: t_o = 9'd253;
      7'd72: t_o = 9'd253;  7'd73: t_o = 9'd253;  7'd74: t_o = 9'd254;  7'd75: t_o = 9'd254;
      7'd76: t_o = 9'd254;  7'd77: t_o = 9'd254;  7'd78: t_o = 9'd254;  7'd79: t_o = 9'd254;
      7'd80: t_o = 9'd254;  7'd81: t_o = 9'd254;  7'd82: t_o = 9'd254;  7'd83: t_o = 9'd255;
      7'd84: t_o = 9'd255;  7'd85: t_o = 9'd255;  7'd86: t_o = 9'd255;  7'd87: t_o = 9'd255;
      7'd88: t_o = 9'd255;  7'd89: t_o = 9'd255;  7'd90: t_o = 9'd255;  7'd91: t_o = 9'd255;
      7'd92: t_o = 9'd255;  7'd93: t_o = 9'd255;  7'd94: t_o = 9'd255;  7'd95: t_o = 9'd255;
      7'd96: t_o = 9'd255;  7'd97: t_o = 9'd255;  7'd98: t_o = 9'd255;  7'd99: t_o = 9'd255;
      default: t_o = TBL_ONE;
    endcase
  end

endmodule

// File: rtl/sigmoid_lut.sv
// Registered sigmoid of a signed Q4.4 operand, using a half-range table
// and the identity sigmoid(-x) = 1 - sigmoid(x).
module sigmoid_lut
  import sigmoid_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  x_in,
  output logic [OUT_W-1:0] y_out
);

  logic              neg_c;
  logic              min_c;
  logic [ADDR_W-1:0] addr_c;
  logic [TBL_W-1:0]  t_c;
  logic [OUT_W-1:0]  refl_c;
  logic [OUT_W-1:0]  y_d;
  logic [OUT_W-1:0]  y_q;

  // Sign/magnitude split; -128 aliases to address 0 and is handled separately
  always_comb begin
    neg_c  = x_in[IN_W-1];
    min_c  = (x_in == {1'b1, {(IN_W-1){1'b0}}});
    addr_c = neg_c ? ADDR_W'(~x_in[ADDR_W-1:0]) + ADDR_W'(1) : x_in[ADDR_W-1:0];
  end

  sigmoid_rom u_rom (
    .addr_i (addr_c),
    .t_o    (t_c)
  );

  // T never drops below 128, so 256 - T always fits in the output width
  always_comb begin
    refl_c = OUT_W'(TBL_ONE - t_c);
    y_d    = '0;
    if (min_c) begin
      y_d = '0;
    end else if (neg_c) begin
      y_d = refl_c;
    end else if (t_c[TBL_W-1]) begin
      y_d = OUT_MAX;
    end else begin
      y_d = t_c[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y_out = y_q;

endmodule

// File: tb/tb_sigmoid_lut.sv
// Scoreboard bench for sigmoid_lut against a real-valued sigmoid model.
module tb_sigmoid_lut;

  logic       clk;
  logic       reset;
  logic [7:0] x_in;
  logic [7:0] y_out;

  int unsigned exp_q[$];
  int          n_checks;
  int          n_fail;
  logic [7:0]  prev;

  sigmoid_lut dut (
    .clk   (clk),
    .reset (reset),
    .x_in  (x_in),
    .y_out (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned model(input int x);
    real s;
    int  r;
    s = 256.0 / (1.0 + $exp(-$itor(x) / 16.0));
    r = $rtoi($floor(s + 0.5));
    if (r > 255) r = 255;
    return $unsigned(r);
  endfunction

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one operand between edges, then compare one edge later
  task automatic step(input logic [7:0] x, input int unsigned exp, input string tag);
    @(negedge clk);
    x_in = x;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_eq(tag, 32'(y_out), exp_q.pop_front());
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    x_in     = 8'd16;
    prev     = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold", 32'(y_out), 0);
    #1 reset = 1'b0;
    step(8'd16, 187, "rst_release");

    step(8'd0,   128, "key_0");
    step(8'd16,  187, "key_16");
    step(8'hF0,  69,  "key_m16");
    step(8'd32,  225, "key_32");
    step(8'hE0,  31,  "key_m32");
    step(8'hFF,  124, "key_m1");

    step(8'd127, 255, "ext_127");
    step(8'd100, 255, "ext_100");
    step(8'h80,  0,   "ext_m128");
    step(8'h9C,  0,   "ext_m100");
    step(8'd99,  255, "ext_99");
    step(8'h9D,  1,   "ext_m99");

    for (int i = -128; i <= 127; i++) begin
      step(8'(i), model(i), "sweep");
      if (i > -128) check_eq("mono", 32'(y_out >= prev), 1);
      prev = y_out;
      if (i == 40) begin
        #1 reset = 1'b1;
        #1 check_eq("rst_async", 32'(y_out), 0);
        @(posedge clk);
        #1 check_eq("rst_inflight", 32'(y_out), 0);
        #1 reset = 1'b0;
      end
    end

    for (int r = 0; r < 3; r++) begin
      step(8'd127, 255, "alt_127");
      step(8'h80,  0,   "alt_m128");
      step(8'd0,   128, "alt_0");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
